// File: rtl/matriz_display_scheduler.sv
// Display scheduler for the battleship 5x7 LED matrix: picks blank, board preview
// with blinking cursor, or hit map, and runs the timed hit-flash animation.
module matriz_display_scheduler #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_DIV   = 25,
    parameter int FLASH_COUNT = 3,
    parameter int FLASH_TICKS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_preview,
    input  logic        req_hits,
    input  logic        hit_evt,
    input  logic [34:0] board,
    input  logic [34:0] hits,
    input  logic [2:0]  cursor_col,
    input  logic [2:0]  cursor_line,
    output logic [1:0]  show,
    output logic [6:0]  col1,
    output logic [6:0]  col2,
    output logic [6:0]  col3,
    output logic [6:0]  col4,
    output logic [6:0]  col5,
    output logic [6:0]  colHit1,
    output logic [6:0]  colHit2,
    output logic [6:0]  colHit3,
    output logic [6:0]  colHit4,
    output logic [6:0]  colHit5,
    output logic        scan_tick,
    output logic        flash_active
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(FLASH_TICKS + 1);
    localparam int LW = $clog2(FLASH_COUNT + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREVIEW,
        S_HITS,
        S_FLASH_ON,
        S_FLASH_OFF
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler: the tick register is loaded one count early so that it is
    // high exactly while the counter holds SCAN_DIV-1.
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_reg;
    logic          tick_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            if (pre_reg == PW'(SCAN_DIV - 1)) begin
                pre_reg <= '0;
            end else begin
                pre_reg <= pre_reg + PW'(1);
            end
            tick_reg <= (pre_reg == PW'(SCAN_DIV - 2));
        end
    end

    assign scan_tick = tick_reg;

    // ------------------------------------------------------------------
    // State machine and timers
    // ------------------------------------------------------------------
    state_t        state_reg, state_next, req_state;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic [LW-1:0] left_reg, left_next;
    logic [BW-1:0] bcnt_reg, bcnt_next;
    logic          blink_reg, blink_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            tmr_reg   <= '0;
            left_reg  <= '0;
            bcnt_reg  <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
            left_reg  <= left_next;
            bcnt_reg  <= bcnt_next;
            blink_reg <= blink_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        left_next  = left_reg;
        bcnt_next  = bcnt_reg;
        blink_next = blink_reg;

        if (req_preview) begin
            req_state = S_PREVIEW;
        end else if (req_hits) begin
            req_state = S_HITS;
        end else begin
            req_state = S_IDLE;
        end

        if (hit_evt) begin
            state_next = S_FLASH_ON;
            left_next  = LW'(FLASH_COUNT);
            tmr_next   = '0;
        end else begin
            case (state_reg)
                S_FLASH_ON: begin
                    if (tick_reg) begin
                        if (tmr_reg == TW'(FLASH_TICKS - 1)) begin
                            state_next = S_FLASH_OFF;
                            tmr_next   = '0;
                        end else begin
                            tmr_next = tmr_reg + TW'(1);
                        end
                    end
                end
                S_FLASH_OFF: begin
                    if (tick_reg) begin
                        if (tmr_reg == TW'(FLASH_TICKS - 1)) begin
                            tmr_next  = '0;
                            left_next = left_reg - LW'(1);
                            // Last pair finished: fall back to whatever is requested now.
                            if (left_reg == LW'(1)) begin
                                state_next = req_state;
                            end else begin
                                state_next = S_FLASH_ON;
                            end
                        end else begin
                            tmr_next = tmr_reg + TW'(1);
                        end
                    end
                end
                default: begin
                    state_next = req_state;
                end
            endcase
        end

        // Blink restarts dark on every fresh entry and is frozen elsewhere.
        if (state_next == S_PREVIEW) begin
            if (state_reg != S_PREVIEW) begin
                blink_next = 1'b0;
                bcnt_next  = '0;
            end else if (tick_reg) begin
                if (bcnt_reg == BW'(BLINK_DIV - 1)) begin
                    bcnt_next  = '0;
                    blink_next = ~blink_reg;
                end else begin
                    bcnt_next = bcnt_reg + BW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Column words
    // ------------------------------------------------------------------
    logic             cursor_valid;
    logic [4:0][6:0]  preview_cols;

    assign cursor_valid = (cursor_col <= 3'd4) && (cursor_line <= 3'd6);

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cols
            logic cursor_here;
            assign cursor_here      = cursor_valid && (cursor_col == 3'(gi)) && blink_next;
            assign preview_cols[gi] = board[gi*7 +: 7]
                                    ^ (cursor_here ? (7'b0000001 << cursor_line) : 7'b0000000);
        end
    endgenerate

    logic [1:0]       show_reg, show_next;
    logic [4:0][6:0]  col_reg, col_next;
    logic [4:0][6:0]  hit_reg, hit_next;
    logic             fa_reg, fa_next;

    always_comb begin
        show_next = 2'b00;
        col_next  = '0;
        hit_next  = '0;
        fa_next   = 1'b0;
        case (state_next)
            S_PREVIEW: begin
                show_next = 2'b01;
                col_next  = preview_cols;
            end
            S_HITS: begin
                show_next = 2'b10;
                hit_next  = hits;
            end
            S_FLASH_ON: begin
                show_next = 2'b10;
                hit_next  = hits;
                fa_next   = 1'b1;
            end
            S_FLASH_OFF: begin
                show_next = 2'b10;
                fa_next   = 1'b1;
            end
            default: begin
                show_next = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            show_reg <= 2'b00;
            col_reg  <= '0;
            hit_reg  <= '0;
            fa_reg   <= 1'b0;
        end else begin
            show_reg <= show_next;
            col_reg  <= col_next;
            hit_reg  <= hit_next;
            fa_reg   <= fa_next;
        end
    end

    assign show         = show_reg;
    assign flash_active = fa_reg;
    assign col1         = col_reg[0];
    assign col2         = col_reg[1];
    assign col3         = col_reg[2];
    assign col4         = col_reg[3];
    assign col5         = col_reg[4];
    assign colHit1      = hit_reg[0];
    assign colHit2      = hit_reg[1];
    assign colHit3      = hit_reg[2];
    assign colHit4      = hit_reg[3];
    assign colHit5      = hit_reg[4];

endmodule
